// File: rtl/simon_128_192.sv
// SIMON 128/192 block cipher: iterative core doing one round per clock, with an
// on-chip key expansion that stores every round key before data is accepted.
module simon_128_192 #(
  parameter int N  = 64,
  parameter int M  = 3,
  parameter int T  = 69,
  parameter int Co = 7
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [1:0][N-1:0]   inData,
  input  logic [M-1:0][N-1:0] key,
  output logic                loadData,
  output logic                loadKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [1:0][N-1:0]   outData,
  output logic [3:0]          mode
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    KEYEXP = 4'd1,
    READY  = 4'd2,
    RUN    = 4'd3,
    DONE   = 4'd4
  } state_e;

  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  state_e              state_q, state_d;
  logic [Co-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        x_q, x_d, y_q, y_d;
  logic                encd_q, encd_d;
  logic [1:0][N-1:0]   out_q, out_d;
  logic                load_data_q, load_data_d;
  logic                load_key_q, load_key_d;
  logic                done_data_q, done_data_d;
  logic                done_key_q, done_key_d;
  logic [N-1:0]        rk_q [T];

  logic                key_cap, key_we, start_key;
  logic [Co-1:0]       rk_idx, ki, zsel;
  logic                z_bit;
  logic [N-1:0]        rk_cur, k_im3, k_im1, k_new;

  // Decrypt walks the schedule backwards; out-of-range count only occurs on the
  // output cycle where the key is unused.
  always_comb begin
    rk_idx = '0;
    if (cnt_q < Co'(T)) rk_idx = encd_q ? cnt_q : Co'(T - 1) - cnt_q;
  end
  assign rk_cur = rk_q[rk_idx];

  always_comb begin
    ki    = cnt_q - Co'(3);
    zsel  = (ki >= Co'(62)) ? ki - Co'(62) : ki;
    z_bit = Z3[6'd61 - 6'(zsel)];
    k_im3 = rk_q[cnt_q - Co'(3)];
    k_im1 = rk_q[cnt_q - Co'(1)];
    // ~k ^ 3 folds the schedule constant 2^N - 4 into the inversion
    k_new = ~k_im3 ^ ror(k_im1, 3) ^ ror(k_im1, 4) ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    encd_d      = encd_q;
    out_d       = out_q;
    load_data_d = 1'b0;
    load_key_d  = 1'b0;
    done_data_d = done_data_q;
    done_key_d  = done_key_q;
    key_cap     = 1'b0;
    key_we      = 1'b0;
    start_key   = 1'b0;
    unique case (state_q)
      IDLE: if (newKey) start_key = 1'b1;
      KEYEXP: begin
        key_we = 1'b1;
        cnt_d  = cnt_q + Co'(1);
        if (cnt_q == Co'(T - 1)) begin
          done_key_d = 1'b1;
          cnt_d      = '0;
          state_d    = READY;
        end
      end
      READY: begin
        if (newKey) start_key = 1'b1;
        else if (newData) begin
          x_d         = inData[1];
          y_d         = inData[0];
          encd_d      = enc_dec;
          load_data_d = 1'b1;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (cnt_q == Co'(T)) begin
          out_d       = {x_q, y_q};
          done_data_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + Co'(1);
          if (encd_q) begin
            x_d = y_q ^ simon_f(x_q) ^ rk_cur;
            y_d = x_q;
          end else begin
            x_d = y_q;
            y_d = x_q ^ simon_f(y_q) ^ rk_cur;
          end
        end
      end
      DONE: begin
        if (readData) begin
          done_data_d = 1'b0;
          state_d     = READY;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_key) begin
      key_cap    = 1'b1;
      load_key_d = 1'b1;
      done_key_d = 1'b0;
      cnt_d      = Co'(3);
      state_d    = KEYEXP;
    end
  end

  always_ff @(posedge clk) begin
    if (nR) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      encd_q      <= 1'b0;
      out_q       <= '0;
      load_data_q <= 1'b0;
      load_key_q  <= 1'b0;
      done_data_q <= 1'b0;
      done_key_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      encd_q      <= encd_d;
      out_q       <= out_d;
      load_data_q <= load_data_d;
      load_key_q  <= load_key_d;
      done_data_q <= done_data_d;
      done_key_q  <= done_key_d;
    end
  end

  // Round key storage is left unreset; doneKey gates its use.
  always_ff @(posedge clk) begin
    if (!nR) begin
      if (key_cap) begin
        for (int j = 0; j < M; j++) rk_q[j] <= key[j];
      end else if (key_we) begin
        rk_q[cnt_q] <= k_new;
      end
    end
  end

  assign loadData = load_data_q;
  assign loadKey  = load_key_q;
  assign doneData = done_data_q;
  assign doneKey  = done_key_q;
  assign outData  = out_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_simon_128_192.sv
// Scoreboard bench for simon_128_192: stimulus pushes expected blocks, a
// negedge monitor pops and compares on each doneData rise.
module tb_simon_128_192;

  localparam logic [191:0] K  = 192'h1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [127:0] P0 = 128'h206572656874206E_6568772065626972;
  localparam logic [127:0] C0 = 128'hC4AC61EFFCDC0D4F_6C9C8D6E2597B85B;
  localparam logic [61:0]  Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  logic              clk = 1'b0;
  logic              nR, newData, newKey, enc_dec, readData;
  logic [1:0][63:0]  inData;
  logic [2:0][63:0]  key;
  logic              loadData, loadKey, doneData, doneKey;
  logic [1:0][63:0]  outData;
  logic [3:0]        mode;

  simon_128_192 dut (
    .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
    .readData(readData), .inData(inData), .key(key), .loadData(loadData),
    .loadKey(loadKey), .doneData(doneData), .doneKey(doneKey), .outData(outData),
    .mode(mode)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ld_cnt = 0;
  int lk_cnt = 0;
  logic done_prev = 1'b0;
  logic [127:0] sb [$];
  logic [127:0] mon_exp;
  logic [127:0] last_exp;
  bit pend = 1'b0;

  logic [63:0]  mk [69];
  logic [127:0] pt [5];
  logic [127:0] ct [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model written from the published SIMON algorithm.
  function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction
  function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  task automatic model_keys(input logic [191:0] k);
    logic [63:0] t;
    mk[0] = k[63:0];
    mk[1] = k[127:64];
    mk[2] = k[191:128];
    for (int i = 0; i < 66; i++) begin
      t = ror64(mk[i+2], 3);
      t = t ^ ror64(t, 1);
      mk[i+3] = ~mk[i] ^ t ^ {63'd0, Z3[61 - (i % 62)]} ^ 64'd3;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] p);
    logic [63:0] x, y, t;
    x = p[127:64];
    y = p[63:0];
    for (int i = 0; i < 69; i++) begin
      t = x;
      x = y ^ ((rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2)) ^ mk[i];
      y = t;
    end
    return {x, y};
  endfunction

  always @(negedge clk) begin
    if (loadData) ld_cnt <= ld_cnt + 1;
    if (loadKey)  lk_cnt <= lk_cnt + 1;
    if (doneData && !done_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL outData: unexpected result %h", outData);
      end else begin
        mon_exp = sb.pop_front();
        chk("outData", outData, mon_exp);
      end
    end
    done_prev <= doneData;
  end

  task automatic wait_for(input int which, input int bound, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = loadKey;
        1:       hit = loadData;
        2:       hit = doneKey;
        default: hit = doneData;
      endcase
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_sig%0d: not seen within %0d cycles", which, bound);
    end
  endtask

  task automatic read_pulse();
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    chk("read_clr_done", 128'(doneData), 128'(0));
    chk("read_mode", 128'(mode), 128'(2));
    pend = 1'b0;
  endtask

  task automatic load_key(input logic [191:0] k, input logic [3:0] mode0);
    int n, c0;
    chk("key_mode_pre", 128'(mode), 128'(mode0));
    c0 = lk_cnt;
    key = k;
    newKey = 1'b1;
    wait_for(0, 10, n);
    newKey = 1'b0;
    chk("key_mode_exp", 128'(mode), 128'(1));
    chk("key_donekey_clr", 128'(doneKey), 128'(0));
    wait_for(2, 200, n);
    chk("key_latency", 128'(n), 128'(66));
    chk("key_mode_ready", 128'(mode), 128'(2));
    chk("key_pulses", 128'(lk_cnt - c0), 128'(1));
  endtask

  task automatic blk(input logic [127:0] din, input logic ed, input logic [127:0] exp, input bit poke);
    int n, pre, c0;
    inData  = din;
    enc_dec = ed;
    newData = 1'b1;
    if (pend) begin
      c0 = ld_cnt;
      repeat (3) @(negedge clk);
      chk("hold_noload", 128'(ld_cnt - c0), 128'(0));
      chk("hold_done", 128'(doneData), 128'(1));
      chk("hold_out", outData, last_exp);
      read_pulse();
    end
    sb.push_back(exp);
    wait_for(1, 10, n);
    newData = 1'b0;
    enc_dec = ~ed;
    pre = 0;
    if (poke) begin
      repeat (10) @(negedge clk);
      c0 = lk_cnt;
      key = ~K;
      newKey = 1'b1;
      repeat (5) @(negedge clk);
      newKey = 1'b0;
      key = K;
      chk("run_key_ignored", 128'(lk_cnt - c0), 128'(0));
      chk("run_mode", 128'(mode), 128'(3));
      chk("run_donekey", 128'(doneKey), 128'(1));
      pre = 15;
    end
    wait_for(3, 200, n);
    chk("done_latency", 128'(pre + n), 128'(70));
    last_exp = exp;
    pend = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c0;
    nR = 1'b1; newData = 1'b0; newKey = 1'b0; enc_dec = 1'b0; readData = 1'b0;
    inData = '0; key = '0;
    pt[0] = P0;
    pt[1] = 128'h0;
    pt[2] = {128{1'b1}};
    pt[3] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    pt[4] = 128'h8000000000000000_0000000000000001;
    model_keys(K);
    for (int i = 0; i < 5; i++) ct[i] = model_enc(pt[i]);
    ct[0] = C0;

    repeat (2) @(negedge clk);
    nR = 1'b0;
    chk("rst_mode", 128'(mode), 128'(0));
    chk("rst_loaddata", 128'(loadData), 128'(0));
    chk("rst_loadkey", 128'(loadKey), 128'(0));
    chk("rst_donedata", 128'(doneData), 128'(0));
    chk("rst_donekey", 128'(doneKey), 128'(0));
    chk("rst_outdata", outData, 128'(0));

    // Data and read requests before any key must be ignored.
    c0 = ld_cnt;
    inData = P0; enc_dec = 1'b1; newData = 1'b1; readData = 1'b1;
    repeat (5) @(negedge clk);
    newData = 1'b0; readData = 1'b0;
    chk("idle_noload", 128'(ld_cnt - c0), 128'(0));
    chk("idle_mode", 128'(mode), 128'(0));

    load_key(K, 4'd0);
    blk(P0, 1'b1, C0, 1'b0);
    blk(C0, 1'b0, P0, 1'b0);
    for (int i = 0; i < 5; i++) blk(pt[i], 1'b1, ct[i], 1'b0);
    for (int i = 0; i < 5; i++) blk(ct[i], 1'b0, pt[i], 1'b0);
    blk(pt[3], 1'b1, ct[3], 1'b1);
    read_pulse();
    chk("out_persist", outData, ct[3]);

    load_key(K, 4'd2);
    blk(P0, 1'b1, C0, 1'b0);
    read_pulse();

    // Reset mid-RUN.
    inData = P0; enc_dec = 1'b1; newData = 1'b1;
    wait_for(1, 10, n);
    newData = 1'b0;
    repeat (20) @(negedge clk);
    nR = 1'b1;
    @(negedge clk);
    nR = 1'b0;
    chk("midrst_mode", 128'(mode), 128'(0));
    chk("midrst_loaddata", 128'(loadData), 128'(0));
    chk("midrst_loadkey", 128'(loadKey), 128'(0));
    chk("midrst_donedata", 128'(doneData), 128'(0));
    chk("midrst_donekey", 128'(doneKey), 128'(0));
    chk("midrst_outdata", outData, 128'(0));
    c0 = ld_cnt;
    newData = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_noload", 128'(ld_cnt - c0), 128'(0));
    chk("midrst_idle", 128'(mode), 128'(0));

    // newKey and newData together: key first, data once READY.
    key = K; newKey = 1'b1;
    sb.push_back(C0);
    wait_for(0, 10, n);
    newKey = 1'b0;
    wait_for(1, 200, n);
    newData = 1'b0;
    chk("key_then_data", 128'(n), 128'(67));
    wait_for(3, 200, n);
    chk("simul_latency", 128'(n), 128'(70));
    pend = 1'b1;
    read_pulse();

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
